// File: rtl/mux8x1_pkg.sv
// mux8x1_pkg
// Shared definitions for the round-robin scheduled 8:1 mux.
//   state_t  : scheduler FSM states (IDLE = nobody owns the line,
//              GRANT = exactly one requester owns the line)
//   CNT_W    : width of the per-grant hold counter
//   rrPick() : round-robin winner search used by the scheduler
package mux8x1_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int CNT_W = 4;

  // Returns the first requester at or after (last+1) mod 8, wrapping
  // around so that 'last' itself is the final candidate. The caller must
  // check that req is non-zero; with no requests this returns 'last'.
  function automatic logic [2:0] rrPick(input logic [7:0] req,
                                        input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux8x1.sv
// mux8x1
// Plain combinational 8:1 bit multiplexer.
//   S : 3-bit select
//   D : 8 data inputs, D[i] is input i
//   Y : selected data bit, D[S]
module mux8x1 (
  input  logic [2:0] S,
  input  logic [7:0] D,
  output logic       Y
);

  assign Y = D[S];

endmodule

// File: rtl/mux8x1_rr_sched.sv
// mux8x1_rr_sched
// Shares one serial line among eight requesters. A round-robin scheduler
// grants the line to one requester at a time for at most HOLD consecutive
// cycles, and an 8:1 mux forwards the grantee's data onto Y.
//   HOLD  : max consecutive granted cycles per grant (legal 1..15)
//   CLK   : clock, all state changes on the rising edge
//   RST   : synchronous active-high reset
//   REQ   : request vector, REQ[i] = requester i wants the line
//   D     : data vector, D[i] = serial data of requester i
//   S     : registered select, index of current or last grantee
//   GNT   : registered one-hot grant, zero when nobody is granted
//   VALID : registered, high while a grant is active
//   Y     : shared line, D[S] while VALID, else 0 (combinational)
module mux8x1_rr_sched
  import mux8x1_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ,
  input  logic [7:0] D,
  output logic [2:0] S,
  output logic [7:0] GNT,
  output logic       VALID,
  output logic       Y
);

  // Counter value reached in the last cycle a grant may be kept.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic [2:0]       winner;
  logic             anyReq;
  logic             release_w;
  logic             muxY;

  assign winner    = rrPick(REQ, last_q);
  assign anyReq    = |REQ;
  // Dropping the request and running out of hold time are one release.
  assign release_w = !REQ[sel_q] || (holdCnt_q == HOLD_LAST);

  // Next-state logic. A new grant (from IDLE or at a release) always
  // restarts the hold counter and moves LAST to the winner, even when the
  // winner is the requester that just released.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;

    unique case (state_q)
      IDLE: begin
        gnt_d   = 8'h00;
        valid_d = 1'b0;
        if (anyReq) begin
          state_d   = GRANT;
          sel_d     = winner;
          gnt_d     = 8'h01 << winner;
          valid_d   = 1'b1;
          holdCnt_d = '0;
          last_d    = winner;
        end
      end
      GRANT: begin
        if (release_w) begin
          if (anyReq) begin
            sel_d     = winner;
            gnt_d     = 8'h01 << winner;
            valid_d   = 1'b1;
            holdCnt_d = '0;
            last_d    = winner;
          end else begin
            state_d   = IDLE;
            gnt_d     = 8'h00;
            valid_d   = 1'b0;
            holdCnt_d = '0;
          end
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. LAST resets to 7 so requester 0 wins first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      last_q    <= 3'd7;
      sel_q     <= 3'd0;
      gnt_q     <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
    end
  end

  mux8x1 u_mux (
    .S (sel_q),
    .D (D),
    .Y (muxY)
  );

  assign S     = sel_q;
  assign GNT   = gnt_q;
  assign VALID = valid_q;
  assign Y     = muxY & valid_q;

endmodule

// File: tb/tb_mux8x1_rr_sched.sv
// tb_mux8x1_rr_sched
// Directed self-checking bench for mux8x1_rr_sched with HOLD=4.
module tb_mux8x1_rr_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ;
  logic [7:0] D;
  logic [2:0] S;
  logic [7:0] GNT;
  logic       VALID;
  logic       Y;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] dPat;

  mux8x1_rr_sched #(.HOLD(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .D     (D),
    .S     (S),
    .GNT   (GNT),
    .VALID (VALID),
    .Y     (Y)
  );

  always #5 CLK = ~CLK;

  // Drive inputs, clock one edge, and settle 1ns past the edge.
  task automatic applyStimulus(input logic rst, input logic [7:0] req,
                               input logic [7:0] d);
    RST = rst;
    REQ = req;
    D   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    REQ = 8'hFF;
    D   = 8'hFF;

    // Reset held for two cycles with everything requesting.
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    checkOutput("rst S", S, 3'd0);
    checkOutput("rst GNT", GNT, 8'h00);
    checkOutput("rst VALID", VALID, 1'b0);
    checkOutput("rst Y", Y, 1'b0);
    checkOutput("rst cnt", dut.holdCnt_q, 4'd0);
    checkOutput("rst last", dut.last_q, 3'd7);

    // All requesting: requester 0 first, then each in turn for 4 cycles.
    dPat = 8'hA5;
    applyStimulus(1'b0, 8'hFF, dPat);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(g == 0 && c == 0)) applyStimulus(1'b0, 8'hFF, dPat);
        checkOutput("all S", S, 32'(g % 8));
        checkOutput("all GNT", GNT, 32'(8'h01 << (g % 8)));
        checkOutput("all cnt", dut.holdCnt_q, 32'(c));
        checkOutput("all VALID", VALID, 1'b1);
        checkOutput("all Y", Y, dPat[g % 8]);
      end
    end

    // Sole continuous requester: re-granted back to back.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h01, 8'h01);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) applyStimulus(1'b0, 8'h01, 8'h01);
      checkOutput("sole GNT", GNT, 8'h01);
      checkOutput("sole Y", Y, 1'b1);
      checkOutput("sole cnt", dut.holdCnt_q, 32'(i % 4));
      checkOutput("sole last", dut.last_q, 3'd0);
    end
    // Y follows D[S] without waiting for a clock edge.
    D = 8'h00;
    #1;
    checkOutput("comb Y lo", Y, 1'b0);
    D = 8'h01;
    #1;
    checkOutput("comb Y hi", Y, 1'b1);

    // Two requesters alternate every 4 cycles with no VALID gap.
    applyStimulus(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'h81, 8'h00);
      checkOutput("two S", S, ((i / 4) % 2 == 1) ? 3'd7 : 3'd0);
      checkOutput("two VALID", VALID, 1'b1);
    end

    // Early drop: grantee 3 drops after 2 cycles, requester 5 takes over.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h08, 8'hFF);
    checkOutput("drop S0", S, 3'd3);
    checkOutput("drop cnt0", dut.holdCnt_q, 4'd0);
    applyStimulus(1'b0, 8'h28, 8'hFF);
    checkOutput("drop S1", S, 3'd3);
    checkOutput("drop GNT1", GNT, 8'h08);
    checkOutput("drop cnt1", dut.holdCnt_q, 4'd1);
    applyStimulus(1'b0, 8'h20, 8'hFF);
    checkOutput("drop S", S, 3'd5);
    checkOutput("drop GNT", GNT, 8'h20);
    checkOutput("drop cnt", dut.holdCnt_q, 4'd0);

    // Grantee drops with nobody else asking: back to IDLE, S kept.
    applyStimulus(1'b0, 8'h00, 8'hFF);
    checkOutput("idle GNT", GNT, 8'h00);
    checkOutput("idle VALID", VALID, 1'b0);
    checkOutput("idle S", S, 3'd5);
    checkOutput("idle Y", Y, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'hFF);
    checkOutput("idle2 VALID", VALID, 1'b0);

    // Drop and hold expiry on the same edge count as a single release.
    applyStimulus(1'b0, 8'h03, 8'h00);
    checkOutput("both S0", S, 3'd0);
    applyStimulus(1'b0, 8'h03, 8'h00);
    applyStimulus(1'b0, 8'h03, 8'h00);
    applyStimulus(1'b0, 8'h03, 8'h00);
    checkOutput("both cnt3", dut.holdCnt_q, 4'd3);
    applyStimulus(1'b0, 8'h02, 8'h00);
    checkOutput("both S", S, 3'd1);
    checkOutput("both cnt", dut.holdCnt_q, 4'd0);

    // Reset in the middle of a grant to requester 6.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h40, 8'hFF);
    checkOutput("mid S", S, 3'd6);
    applyStimulus(1'b0, 8'h40, 8'hFF);
    applyStimulus(1'b1, 8'h41, 8'hFF);
    checkOutput("mid rst GNT", GNT, 8'h00);
    checkOutput("mid rst VALID", VALID, 1'b0);
    checkOutput("mid rst Y", Y, 1'b0);
    applyStimulus(1'b0, 8'h41, 8'hFF);
    checkOutput("mid S after", S, 3'd0);
    checkOutput("mid GNT after", GNT, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mux8x1_rr_sched.md
MUX8X1_RR_SCHED -- requirements
Module: mux8x1_rr_sched

Interface
REQ-001 Parameter: HOLD, default 4, maximum consecutive granted cycles per requester; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 REQ  input  8  request vector; REQ[i] high = requester i wants the shared line.
REQ-005 D    input  8  data vector; D[i] = serial data of requester i.
REQ-006 S    output 3  registered select driven to the 8:1 mux; index of the current or last grantee.
REQ-007 GNT  output 8  registered one-hot grant; all-zero when no grant is active.
REQ-008 VALID output 1  registered; high while a grant is active (equals |GNT).
REQ-009 Y    output 1  shared line; equals D[S] when VALID=1, else 0.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the line).
REQ-011 The block SHALL keep a registered round-robin pointer LAST (3 bits) holding the most recent grantee.
REQ-012 Arbitration SHALL select the first i with REQ[i]=1, searching (LAST+1) mod 8 upward with wrap-around through LAST itself.
REQ-013 In IDLE with REQ≠0 at edge k, the block SHALL enter GRANT at edge k, with S=winner, GNT=1<<winner, VALID=1 visible after that edge (one-cycle latency).
REQ-014 In IDLE with REQ=0, the block SHALL stay in IDLE with GNT=0, VALID=0, S unchanged.
REQ-015 In GRANT, a 4-bit hold counter SHALL be 0 in the first granted cycle and increment by 1 on each edge the grant is kept.
REQ-016 Release SHALL occur at an edge where REQ[S]=0 or the counter equals HOLD-1; both together count as one release.
REQ-017 On release, if REQ≠0 (current grantee included), the block SHALL grant the next winner per REQ-012 at the same edge with no idle cycle and reset the counter to 0; otherwise it SHALL go to IDLE.
REQ-018 A sole continuous requester SHALL be re-granted back-to-back; GNT stays high across the boundary and the counter restarts.
REQ-019 LAST SHALL update to the winner on every new grant, including re-grants.
REQ-020 Y SHALL be combinational from S, D and VALID; a change on D[S] SHALL appear on Y in the same cycle.
REQ-021 REQ changes on non-granted lines during GRANT SHALL NOT affect S or GNT until the next release.
REQ-022 GNT SHALL never have more than one bit set.

Reset
REQ-023 With RST=1 at an edge: state=IDLE, S=000, GNT=00000000, VALID=0, counter=0, LAST=111 (so requester 0 has first priority).
REQ-024 Reset SHALL override any activity, including an active grant mid-hold; Y SHALL be 0 in the cycle after the reset edge.
REQ-025 The first edge with RST=0 SHALL arbitrate normally per REQ-013.

Structure
REQ-026 FSM state encodings and the counter width constant (4) SHALL reside in the shared package mux8x1_pkg.
REQ-027 The block SHALL instantiate the existing mux8x1 (ports S, D, Y) as its single sub-module; Y is its output gated with VALID.
REQ-028 The arbiter search SHALL be a combinational function; FSM, counter, LAST, S, GNT and VALID SHALL be registers.

Verification (HOLD=4)
REQ-029 Reset: RST=1 for 2 cycles with REQ=FF, D=FF -> S=000, GNT=00, VALID=0, Y=0; first edge after release -> S=000, GNT=01.
REQ-030 Sole requester: REQ=01 held, D=01 -> GNT=01 continuously, Y=1, counter cycles 0,1,2,3,0.
REQ-031 Two requesters: REQ=81 held -> S sequence 000 x4, 111 x4, 000 x4; no VALID gap.
REQ-032 All requesting: REQ=FF -> S steps 0,1,...,7,0 every 4 cycles; GNT stays one-hot.
REQ-033 Early drop: grantee 3 drops REQ[3] after 2 granted cycles with REQ[5]=1 -> next edge S=101, GNT=20, counter=0.
REQ-034 Mid-grant reset: RST=1 while S=110 -> next edge GNT=00, VALID=0; after RST=0 with REQ=41 -> S=000 first.
